// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES inverse cipher: one inverse round per clock over an expanded key schedule.
// Optional AES_INV_CIPHER_KEYLATCH_EN copies RoundKeys into an internal register on accept.
module aes_inv_cipher_seq #(
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:127]          CipherText,
    input  logic [0:128*(Nr+1)-1] RoundKeys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:127]          Plain
);

    localparam int RCW = $clog2(Nr + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [127:0]            st_r;
    logic [RCW-1:0]          rc_r;
    logic [127:0]            plain_r;
    logic                    accept_s;
    logic                    round_s;
    logic                    final_s;
    logic [0:128*(Nr+1)-1]   keys_s;
    logic [127:0]            rk_s;
    logic [127:0]            isr_s;
    logic [127:0]            isb_s;
    logic [127:0]            ark_s;
    logic [127:0]            imc_s;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        end
        return gf_inv(b ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef AES_INV_CIPHER_KEYLATCH_EN
    logic [0:128*(Nr+1)-1] keys_r;

    // Private copy of the schedule so the caller may change RoundKeys after accept
    always_ff @(posedge clk) begin
        if (reset)         keys_r <= '0;
        else if (accept_s) keys_r <= RoundKeys;
        else               keys_r <= keys_r;
    end

    assign keys_s = keys_r;
`else
    assign keys_s = RoundKeys;
`endif

    // rc reaches 0 on the last round, so the same select yields key[0] in FINAL
    assign rk_s  = keys_s[32'(rc_r) * 128 +: 128];
    assign isr_s = inv_shift_rows(st_r);
    assign isb_s = inv_sub_bytes(isr_s);
    assign ark_s = isb_s ^ rk_s;
    assign imc_s = inv_mix_columns(ark_s);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt_s = ROUND;
                else          state_nxt_s = IDLE;
            end
            ROUND: begin
                if (rc_r == RCW'(1)) state_nxt_s = FINAL;
                else                 state_nxt_s = ROUND;
            end
            FINAL: state_nxt_s = DONE;
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept_s  = 1'b0;
        round_s   = 1'b0;
        final_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                accept_s = in_valid;
            end
            ROUND:   round_s   = 1'b1;
            FINAL:   final_s   = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Round state and round counter
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r <= 128'd0;
            rc_r <= '0;
        end else if (accept_s) begin
            st_r <= CipherText ^ RoundKeys[Nr*128 +: 128];
            rc_r <= RCW'(Nr - 1);
        end else if (round_s) begin
            st_r <= imc_s;
            rc_r <= rc_r - RCW'(1);
        end else begin
            st_r <= st_r;
            rc_r <= rc_r;
        end
    end

    // Output block register, written only by the final round
    always_ff @(posedge clk) begin
        if (reset)        plain_r <= 128'd0;
        else if (final_s) plain_r <= ark_s;
        else              plain_r <= plain_r;
    end

    assign Plain = plain_r;

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Self-checking bench for aes_inv_cipher_seq: FIPS-197 vectors on Nr=10 and Nr=14 instances,
// backpressure, back-to-back issue, mid-block reset and (with AES_INV_CIPHER_KEYLATCH_EN) key latching.
module tb_aes_inv_cipher_seq;

    localparam int NR_A = 10;
    localparam int NR_B = 14;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic                    iv_a, ir_a, ov_a, ordy_a;
    logic [0:127]            ct_a, pt_a;
    logic [0:128*(NR_A+1)-1] rk_a;
    logic                    iv_b, ir_b, ov_b, ordy_b;
    logic [0:127]            ct_b, pt_b;
    logic [0:128*(NR_B+1)-1] rk_b;

    aes_inv_cipher_seq #(.Nr(NR_A)) dut_a (
        .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .CipherText(ct_a),
        .RoundKeys(rk_a), .out_valid(ov_a), .out_ready(ordy_a), .Plain(pt_a)
    );

    aes_inv_cipher_seq #(.Nr(NR_B)) dut_b (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .CipherText(ct_b),
        .RoundKeys(rk_b), .out_valid(ov_b), .out_ready(ordy_b), .Plain(pt_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_a = 0;
    int rise_b = 0;
    int acc_a[$];
    int acc_b[$];
    logic [127:0] q_a[$];
    logic [127:0] q_b[$];
    logic [127:0] exp_a, exp_b;
    logic [0:128*(NR_A+1)-1] rk1_a, rkb_a, rk_acc_a;
    logic [0:128*15-1]       big;

    // Forward S-box, only needed to expand the reference key schedules
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] p, r, b;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        for (int i = 0; i < 8; i++)
            b[i] = r[i] ^ r[(i+4)%8] ^ r[(i+5)%8] ^ r[(i+6)%8] ^ r[(i+7)%8];
        return b ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [0:128*15-1] expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [0:128*15-1] rk;
        rk   = '0;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record accepts into the scoreboard, pop/compare on output handshakes
    task automatic tick();
        logic acc_as, acc_bs, hs_as, hs_bs, ov_ap, ov_bp, rst_p;
        logic [127:0] pa, pb;
        acc_as = iv_a && ir_a;
        acc_bs = iv_b && ir_b;
        hs_as  = ov_a && ordy_a;
        hs_bs  = ov_b && ordy_b;
        ov_ap  = ov_a;
        ov_bp  = ov_b;
        pa     = pt_a;
        pb     = pt_b;
        rst_p  = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_p) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (acc_as) begin q_a.push_back(exp_a); acc_a.push_back(cyc); rk_acc_a = rk_a; end
            if (acc_bs) begin q_b.push_back(exp_b); acc_b.push_back(cyc); end
            if (hs_as) begin
                chk("a_out_pending", {127'd0, q_a.size() > 0}, 128'd1);
                if (q_a.size() > 0) chk("a_plain", pa, q_a.pop_front());
            end
            if (hs_bs) begin
                chk("b_out_pending", {127'd0, q_b.size() > 0}, 128'd1);
                if (q_b.size() > 0) chk("b_plain", pb, q_b.pop_front());
            end
        end
        if (!ov_ap && ov_a) rise_a = cyc;
        if (!ov_bp && ov_b) rise_b = cyc;
`ifndef AES_INV_CIPHER_KEYLATCH_EN
        if (!ir_a && !ov_a && !reset && !rst_p)
            chk("a_key_stable", {127'd0, rk_a === rk_acc_a}, 128'd1);
`endif
    endtask

    task automatic wait_ov(input bit sel_b, input int budget, input string tag);
        int n;
        n = 0;
        while (!(sel_b ? ov_b : ov_a) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_ov_seen"}, {127'd0, sel_b ? ov_b : ov_a}, 128'd1);
    endtask

    // Single C.1-style block on dut_a, consumed immediately once valid
    task automatic run_a(input logic [127:0] ct, input logic [127:0] exp, input string tag);
        ct_a  = ct;
        exp_a = exp;
        iv_a  = 1'b1;
        tick();
        iv_a  = 1'b0;
        wait_ov(1'b0, 40, tag);
        ordy_a = 1'b1;
        tick();
        ordy_a = 1'b0;
        chk({tag, "_drained"}, 128'(q_a.size()), 128'd0);
    endtask

    initial begin
        reset = 1'b1;
        iv_a = 1'b0; ordy_a = 1'b0; ct_a = '0;
        iv_b = 1'b0; ordy_b = 1'b0; ct_b = '0;
        big   = expand_key({K1, 128'd0}, 4, NR_A);
        rk1_a = big[0 +: 128*(NR_A+1)];
        big   = expand_key({KB, 128'd0}, 4, NR_A);
        rkb_a = big[0 +: 128*(NR_A+1)];
        big   = expand_key(K3, 8, NR_B);
        rk_b  = big[0 +: 128*(NR_B+1)];
        rk_a  = rk1_a;
        rk_acc_a = rk1_a;
        exp_a = PT1;
        exp_b = PT1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready_a", ir_a, 1'b1);
        chk("rst_out_valid_a", ov_a, 1'b0);
        chk("rst_plain_a", pt_a, 128'd0);
        chk("rst_in_ready_b", ir_b, 1'b1);
        chk("rst_out_valid_b", ov_b, 1'b0);

        // C.1, Nr=10; edges are counted with the accept edge itself as 1
        ct_a = CT1;
        iv_a = 1'b1;
        tick();
        iv_a = 1'b0;
        chk("t1_busy", ir_a, 1'b0);
        wait_ov(1'b0, 40, "t1");
        chk("t1_latency", 128'(rise_a - acc_a[$] + 1), 128'(NR_A + 1));
        chk("t1_plain", pt_a, PT1);

        // Backpressure: hold for 20 cycles, then release
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_hold_ov", ov_a, 1'b1);
            chk("t3_hold_ir", ir_a, 1'b0);
            chk("t3_hold_plain", pt_a, PT1);
        end
        ordy_a = 1'b1;
        tick();
        ordy_a = 1'b0;
        chk("t3_ov_drop", ov_a, 1'b0);
        chk("t3_ir_back", ir_a, 1'b1);
        chk("t3_drained", 128'(q_a.size()), 128'd0);

        // C.3, Nr=14
        ct_b = CT3;
        iv_b = 1'b1;
        tick();
        iv_b = 1'b0;
        wait_ov(1'b1, 50, "t2");
        chk("t2_latency", 128'(rise_b - acc_b[$] + 1), 128'(NR_B + 1));
        chk("t2_plain", pt_b, PT1);
        ordy_b = 1'b1;
        tick();
        ordy_b = 1'b0;
        chk("t2_ov_drop", ov_b, 1'b0);
        chk("t2_drained", 128'(q_b.size()), 128'd0);

        // Back-to-back with in_valid held and out_ready high
        acc_a.delete();
        ct_a   = CT1;
        iv_a   = 1'b1;
        ordy_a = 1'b1;
        for (int n = 0; n < 60 && acc_a.size() < 2; n++) tick();
        iv_a = 1'b0;
        chk("t4_two_accepts", 128'(acc_a.size()), 128'd2);
        if (acc_a.size() >= 2) chk("t4_interval", 128'(acc_a[1] - acc_a[0] + 1), 128'(NR_A + 3));
        for (int n = 0; n < 40 && q_a.size() > 0; n++) tick();
        ordy_a = 1'b0;
        chk("t4_drained", 128'(q_a.size()), 128'd0);
        tick();

        // Reset in the middle of round 5
        ct_a = CT1;
        iv_a = 1'b1;
        tick();
        iv_a = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_ov", ov_a, 1'b0);
        chk("t5_plain", pt_a, 128'd0);
        chk("t5_ir", ir_a, 1'b1);
        repeat (15) tick();
        chk("t5_no_late_ov", ov_a, 1'b0);
        run_a(CT1, PT1, "t5_fresh");

        // Second vector with a different key
        rk_a = rkb_a;
        tick();
        run_a(CTB, PTB, "tb_vec");
        rk_a = rk1_a;
        tick();

`ifdef AES_INV_CIPHER_KEYLATCH_EN
        // Keys trashed right after accept must not disturb the block
        ct_a  = CT1;
        exp_a = PT1;
        iv_a  = 1'b1;
        tick();
        iv_a  = 1'b0;
        rk_a  = '1;
        wait_ov(1'b0, 40, "t6");
        chk("t6_plain", pt_a, PT1);
        ordy_a = 1'b1;
        tick();
        ordy_a = 1'b0;
        rk_a   = rk1_a;
        chk("t6_drained", 128'(q_a.size()), 128'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
